mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (IF) and the data access of the MEM stage.
- Sequences each bus transaction and latches the response.
- Generates the IF_valid and MEM_valid qualifiers consumed by the pipeline hazard/stall logic.
- Discards fetch responses that a control-flow flush has made obsolete.

Parameters:
- XLEN, 32, data width of read/write data.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 255, bus wait limit before abort (used only with the optional feature); counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_req  in  1  fetch request, held until IF_valid
- IF_addr  in  ADDR_W  fetch address
- IF_flush  in  1  kill outstanding/pending fetch (IF_ID_flush)
- IF_rdata  out  XLEN  fetched instruction
- IF_valid  out  1  fetch complete, 1-cycle pulse
- MEM_req  in  1  data access request, held until MEM_valid pulse
- MEM_we  in  1  1 = store, 0 = load
- MEM_be  in  XLEN/8  byte enables for stores
- MEM_addr  in  ADDR_W  data address
- MEM_wdata  in  XLEN  store data
- MEM_rdata  out  XLEN  load data
- MEM_valid  out  1  data stage not blocking
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write
- bus_be  out  XLEN/8  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  XLEN  bus write data
- bus_ack  in  1  single-cycle completion strobe
- bus_rdata  in  XLEN  read data, valid with bus_ack
- bus_err  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All bus_* outputs 0; IF_valid=0; IF_rdata=0; MEM_rdata=0; discard flag 0; timeout counter 0.
  - MEM_valid=1 (no request pending).
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - MEM_req=1 → latch MEM_addr/we/be/wdata into bus regs, bus_req=1 next cycle, go MEM_BUSY.
  - Else IF_req=1 and IF_flush=0 → latch IF_addr, bus_we=0, bus_be=all-ones, go IF_BUSY.
  - Fixed priority: MEM over IF. No preemption of an active transaction.
- Bus rules:
  - bus_req/addr/we/be/wdata are registered and stable from grant until the cycle bus_ack=1.
  - bus_req drops the cycle after ack.
  - bus_ack while IDLE is ignored.
- IF_BUSY on bus_ack:
  - Capture bus_rdata into IF_rdata; go IDLE.
  - IF_valid=1 for the next cycle only, unless the discard flag is set. If set, suppress IF_valid and clear the flag.
- IF_flush:
  - In IF_BUSY, sets the discard flag; the transaction still completes on the bus.
  - In IDLE, blocks that cycle's fetch grant.
  - Flush and ack in the same cycle → response discarded.
- MEM_valid = ~MEM_req_pending | mem_done_pulse.
  - While MEM_req=1, MEM_valid=0 until the cycle after the MEM ack, where it is 1 for one cycle with MEM_rdata valid (loads).
  - MEM_req=1 on the cycle following the done pulse is treated as a new request.
- Minimum latency: request → grant 1 cycle, ack → valid 1 cycle. A zero-wait bus gives IF_valid 2 cycles after IF_req when idle.
- IF_req held while MEM wins: fetch is granted on the first IDLE cycle with MEM_req=0. The MEM-over-IF order is deliberate: pipeline stall bounds MEM traffic.
- IF_rdata/MEM_rdata hold their last captured value until overwritten.
- Stores: MEM_rdata unchanged.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter runs in IF_BUSY/MEM_BUSY and clears on ack or IDLE.
  - When it reaches TIMEOUT_CYCLES without ack, the transaction is aborted: go IDLE, bus_req drops, sticky bus_err=1 (cleared only by reset).
  - The aborted side receives its valid pulse with rdata = 0, so the pipeline does not deadlock.
- Undefined: no counter; bus waits indefinitely; bus_err tied 0.

Test Plan:
- Reset then idle → bus_req=0, IF_valid=0, MEM_valid=1; bus_ack pulses while idle produce no valid.
- IF_req=1, IF_addr=0x100, zero-wait ack with bus_rdata=0x00000013:
  - bus_addr=0x100 at cycle 1, IF_valid=1 at cycle 2, IF_rdata=0x00000013.
- IF_req and MEM_req both high, MEM load 0x2000:
  - MEM granted first and MEM_valid pulses with rdata.
  - Fetch granted the next IDLE cycle after MEM_req drops.
- Fetch in flight with 3 wait cycles, IF_flush pulsed in wait cycle 2:
  - Ack consumed, no IF_valid.
  - A new IF_req (0x200) is then granted and completes normally.
- Store MEM_we=1, be=4'b0011, addr=0x40, wdata=0xDEADBEEF:
  - bus_we=1 with identical be/addr/wdata held stable across 4 wait cycles.
  - MEM_valid pulses once after ack; MEM_rdata unchanged.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack:
  - Abort after 8 cycles, bus_err=1, valid pulse with rdata=0.
  - bus_err stays 1 until rst_n asserted mid-operation, which returns all outputs to reset values immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory bus arbiter for instruction fetch and data access
//
// Shares one memory bus between the fetch port (IF_*) and the data port
// (MEM_*). Data accesses win over fetches. The arbiter does not preempt a
// transaction once it is granted. Each bus transaction is driven from
// registers, and its response is latched.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   IF_req/IF_addr/IF_flush    fetch request, address, flush of in-flight fetch
//   IF_rdata/IF_valid          fetched word, one-cycle completion pulse
//   MEM_req/we/be/addr/wdata   data access request (held until MEM_valid)
//   MEM_rdata/MEM_valid        load data, "data stage not blocking" qualifier
//   bus_req/we/be/addr/wdata   registered bus command, stable until bus_ack
//   bus_ack/bus_rdata          single-cycle completion strobe and read data
//   bus_err                    sticky timeout flag
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a bus transaction
// after TIMEOUT_CYCLES cycles without an ack. Without the macro, bus_err is
// tied to 0 and the arbiter waits for the ack indefinitely.

module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                IF_req,
  input  logic [ADDR_W-1:0]   IF_addr,
  input  logic                IF_flush,
  output logic [XLEN-1:0]     IF_rdata,
  output logic                IF_valid,
  input  logic                MEM_req,
  input  logic                MEM_we,
  input  logic [XLEN/8-1:0]   MEM_be,
  input  logic [ADDR_W-1:0]   MEM_addr,
  input  logic [XLEN-1:0]     MEM_wdata,
  output logic [XLEN-1:0]     MEM_rdata,
  output logic                MEM_valid,
  output logic                bus_req,
  output logic                bus_we,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_ack,
  input  logic [XLEN-1:0]     bus_rdata,
  output logic                bus_err
);

  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_e;

  state_e             state_q;
  logic               bus_req_q;
  logic               bus_we_q;
  logic [BE_W-1:0]    bus_be_q;
  logic [ADDR_W-1:0]  bus_addr_q;
  logic [XLEN-1:0]    bus_wdata_q;
  logic [XLEN-1:0]    if_rdata_q;
  logic               if_valid_q;
  logic [XLEN-1:0]    mem_rdata_q;
  logic               mem_done_q;
  logic               discard_q;
  logic               discard_d;
  logic               timeout_hit;
  logic               txn_end;

  // A flush that arrives in the same cycle as the ack must still kill the
  // response, so the combined value is used at completion time.
  assign discard_d = discard_q | ((state_q == IF_BUSY) & IF_flush);
  assign txn_end   = (state_q != IDLE) & (bus_ack | timeout_hit);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;

  // The abort fires at the end of the TIMEOUT_CYCLES-th busy cycle without an ack.
  assign timeout_hit = (state_q != IDLE) & ~bus_ack & (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE || bus_ack || timeout_hit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign bus_err = bus_err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MEM_req) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= MEM_we;
            bus_be_q    <= MEM_be;
            bus_addr_q  <= MEM_addr;
            bus_wdata_q <= MEM_wdata;
            state_q     <= MEM_BUSY;
          end else if (IF_req && !IF_flush) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '1;
            bus_addr_q  <= IF_addr;
            bus_wdata_q <= '0;
            state_q     <= IF_BUSY;
          end
        end
        IF_BUSY: begin
          discard_q <= discard_d;
          if (txn_end) begin
            if_rdata_q <= bus_ack ? bus_rdata : '0;
            if_valid_q <= ~discard_d;
            discard_q  <= 1'b0;
            state_q    <= IDLE;
          end
        end
        MEM_BUSY: begin
          if (txn_end) begin
            // Stores leave the last load data in place.
            if (!bus_we_q) begin
              mem_rdata_q <= bus_ack ? bus_rdata : '0;
            end
            mem_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Command registers return to zero once a transaction ends.
      if (txn_end) begin
        bus_req_q   <= 1'b0;
        bus_we_q    <= 1'b0;
        bus_be_q    <= '0;
        bus_addr_q  <= '0;
        bus_wdata_q <= '0;
      end
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign IF_rdata  = if_rdata_q;
  assign IF_valid  = if_valid_q;
  assign MEM_rdata = mem_rdata_q;
  // Data stage blocks only while its request is outstanding.
  assign MEM_valid = ~MEM_req | mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IF_req, IF_flush, IF_valid;
  logic [31:0] IF_addr, IF_rdata;
  logic        MEM_req, MEM_we, MEM_valid;
  logic [3:0]  MEM_be;
  logic [31:0] MEM_addr, MEM_wdata, MEM_rdata;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wait_cnt = 0;
  int          if_pulses = 0;
  logic        idle_ack = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_flush(IF_flush),
    .IF_rdata(IF_rdata), .IF_valid(IF_valid),
    .MEM_req(MEM_req), .MEM_we(MEM_we), .MEM_be(MEM_be), .MEM_addr(MEM_addr),
    .MEM_wdata(MEM_wdata), .MEM_rdata(MEM_rdata), .MEM_valid(MEM_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    bus_t b;
    b.we = we; b.be = be; b.addr = addr; b.wdata = wdata; b.rdata = rdata; b.waits = waits;
    bus_q.push_back(b);
  endtask

  // Bus slave: checks the command each cycle it is presented, acks after the
  // programmed number of wait cycles.
  initial begin
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (rst_n && bus_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected_req actual=1 required=0 addr=%h", bus_addr);
        end else begin
          chk("bus_we", 32'(bus_we), 32'(bus_q[0].we));
          chk("bus_be", 32'(bus_be), 32'(bus_q[0].be));
          chk("bus_addr", bus_addr, bus_q[0].addr);
          chk("bus_wdata", bus_wdata, bus_q[0].wdata);
          if (wait_cnt == bus_q[0].waits) begin
            bus_ack = 1'b1;
            bus_rdata = bus_q[0].rdata;
            void'(bus_q.pop_front());
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else if (idle_ack) begin
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  // Monitor: pops expected responses whenever a valid pulse is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && IF_valid) begin
        if_pulses++;
        if (if_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if_valid_unexpected actual=1 required=0 rdata=%h", IF_rdata);
        end else begin
          chk("if_rdata", IF_rdata, if_q.pop_front());
        end
      end
      if (rst_n && MEM_req && MEM_valid) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_valid_unexpected actual=1 required=0 rdata=%h", MEM_rdata);
        end else begin
          chk("mem_rdata", MEM_rdata, mem_q.pop_front());
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input int waits, input bit chk_lat);
    int lat = 0;
    if_q.push_back(exp_rdata);
    IF_addr = addr;
    IF_req = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      #2;
      if (IF_valid) begin
        lat = n;
        break;
      end
    end
    IF_req = 1'b0;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL if_timeout actual=no_valid required=valid addr=%h", addr);
    end else if (chk_lat) begin
      chk("if_latency", 32'(lat), 32'(waits + 2));
    end
  endtask

  task automatic do_mem(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    bit got = 1'b0;
    mem_q.push_back(exp_rdata);
    MEM_we = we; MEM_be = be; MEM_addr = addr; MEM_wdata = wdata;
    MEM_req = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      #2;
      if (MEM_valid) begin
        got = 1'b1;
        break;
      end
    end
    MEM_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL mem_timeout actual=no_valid required=valid addr=%h", addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses0;
    rst_n = 1'b0;
    IF_req = 1'b0; IF_addr = '0; IF_flush = 1'b0;
    MEM_req = 1'b0; MEM_we = 1'b0; MEM_be = '0; MEM_addr = '0; MEM_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_if_valid", 32'(IF_valid), 32'd0);
    chk("rst_mem_valid", 32'(MEM_valid), 32'd1);
    chk("rst_if_rdata", IF_rdata, 32'd0);
    chk("rst_mem_rdata", MEM_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // Acks on an idle bus must not create responses.
    pulses0 = if_pulses;
    idle_ack = 1'b1;
    repeat (4) @(negedge clk);
    idle_ack = 1'b0;
    @(negedge clk);
    #2;
    chk("idle_ack_if_pulses", 32'(if_pulses), 32'(pulses0));
    chk("idle_ack_bus_req", 32'(bus_req), 32'd0);
    chk("idle_ack_mem_valid", 32'(MEM_valid), 32'd1);

    // Zero-wait fetch: bus at cycle 1, IF_valid at cycle 2.
    push_bus(1'b0, 4'hF, 32'h100, 32'h0, 32'h0000_0013, 0);
    do_fetch(32'h100, 32'h0000_0013, 0, 1'b1);

    // Fetch and load together: load first, fetch after MEM_req drops.
    push_bus(1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE_0001, 1);
    push_bus(1'b0, 4'hF, 32'h104, 32'h0, 32'h0010_0093, 0);
    fork
      do_mem(1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE_0001);
      do_fetch(32'h104, 32'h0010_0093, 0, 1'b0);
    join

    // Fetch with 3 wait cycles flushed in wait cycle 2: response dropped.
    pulses0 = if_pulses;
    push_bus(1'b0, 4'hF, 32'h180, 32'h0, 32'h0000_0BAD, 3);
    IF_addr = 32'h180;
    IF_req = 1'b1;
    @(negedge clk);
    #2;
    IF_req = 1'b0;
    @(negedge clk);
    #2;
    IF_flush = 1'b1;
    @(negedge clk);
    #2;
    IF_flush = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("flush_if_pulses", 32'(if_pulses), 32'(pulses0));
    chk("flush_bus_req", 32'(bus_req), 32'd0);
    push_bus(1'b0, 4'hF, 32'h200, 32'h0, 32'h0000_0093, 0);
    do_fetch(32'h200, 32'h0000_0093, 0, 1'b1);

    // Store with 4 wait cycles: MEM_rdata keeps the last load value.
    push_bus(1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 32'h5555_AAAA, 4);
    do_mem(1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 32'hCAFE_0001);

    // Load with 2 wait cycles, then a fetch with 1 wait from idle.
    push_bus(1'b0, 4'hF, 32'h44, 32'h0, 32'h1234_5678, 2);
    do_mem(1'b0, 4'hF, 32'h44, 32'h0, 32'h1234_5678);
    push_bus(1'b0, 4'hF, 32'h208, 32'h0, 32'h0020_0113, 1);
    do_fetch(32'h208, 32'h0020_0113, 1, 1'b1);
    chk("if_rdata_hold", IF_rdata, 32'h0020_0113);

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: abort after 8 busy cycles, valid with rdata 0, sticky error.
    push_bus(1'b0, 4'hF, 32'h3F0, 32'h0, 32'h1111_1111, 1000);
    do_fetch(32'h3F0, 32'h0, 7, 1'b1);
    bus_q.delete();
    wait_cnt = 0;
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_bus_req", 32'(bus_req), 32'd0);
`endif

    // Asynchronous reset in the middle of a transaction.
    push_bus(1'b0, 4'hF, 32'h300, 32'h0, 32'h0, 1000);
    IF_addr = 32'h300;
    IF_req = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    chk("midrst_if_rdata", IF_rdata, 32'd0);
    chk("midrst_mem_rdata", MEM_rdata, 32'd0);
    chk("midrst_bus_err", 32'(bus_err), 32'd0);
    chk("midrst_mem_valid", 32'(MEM_valid), 32'd1);
    IF_req = 1'b0;
    bus_q.delete();
    wait_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
